fmap_pixel_streamer: RTL and testbench

//  Source end of the raster pixel stream consumed by the 3x3 sliding-window stage.

---
 rtl/cnn_stream_pkg.sv | 24 ++
 rtl/raster_pos_counter.sv | 45 ++++
 rtl/fmap_pixel_streamer.sv | 117 +++++++++++
 tb/tb_fmap_pixel_streamer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared constants and FSM encoding for the fmap pixel streamer
// Border option is selected by macro STREAM_ZERO_PAD_EN.
package cnn_stream_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_W_DEF  = 128;
    localparam int IMG_H_DEF  = 128;
    localparam int ADDR_W_DEF = 14;

`ifdef STREAM_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int PAD = PAD_EN ? 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/raster_pos_counter.sv
// rtl/raster_pos_counter.sv - output raster column/row counters with wrap, border and last flags
import cnn_stream_pkg::*;

module raster_pos_counter #(
    parameter int OW = 130,
    parameter int OH = 130,
    parameter int CW = 8,
    parameter bit BORDER = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          row_wrap,
    output logic          is_border,
    output logic          last
);

    logic col_end;
    logic row_end;

    assign col_end  = (col == CW'(OW - 1));
    assign row_end  = (row == CW'(OH - 1));
    assign row_wrap = col_end;
    assign last     = col_end && row_end;

    // Without the border every position maps to a stored pixel.
    assign is_border = BORDER && ((row == '0) || row_end || (col == '0) || col_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmap_pixel_streamer.sv
// rtl/fmap_pixel_streamer.sv - raster pixel source reading an int8 feature map from a sync-read buffer
// Define STREAM_ZERO_PAD_EN to add a 1-pixel zero border around the frame.
import cnn_stream_pkg::*;

module fmap_pixel_streamer #(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ready,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [PIX_W-1:0] mem_rdata,
    output logic signed [PIX_W-1:0] pixel_out,
    output logic                    pixel_en,
    output logic                    frame_last,
    output logic                    busy,
    output logic                    done
);

    localparam int OW = IMG_W + 2 * PAD;
    localparam int OH = IMG_H + 2 * PAD;
    localparam int CW = $clog2(((OW > OH) ? OW : OH) + 1);

    stream_state_t state_q, state_d;

    logic [CW-1:0]           pos_col;
    logic [CW-1:0]           pos_row;
    logic                    pos_wrap;
    logic                    pos_border;
    logic                    pos_last;
    logic                    issue;
    logic                    rd_now;
    logic [ADDR_W-1:0]       row_base_q;
    logic [ADDR_W-1:0]       addr_full;
    logic                    en_q;
    logic                    rd_q;
    logic                    last_q;
    logic                    done_q;
    logic signed [PIX_W-1:0] hold_q;

    assign issue  = (state_q == STREAM) && ready;
    assign rd_now = issue && !pos_border;

    raster_pos_counter #(
        .OW     (OW),
        .OH     (OH),
        .CW     (CW),
        .BORDER (PAD_EN)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .advance   (issue),
        .col       (pos_col),
        .row       (pos_row),
        .row_wrap  (pos_wrap),
        .is_border (pos_border),
        .last      (pos_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (issue && pos_last) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // row_base tracks the buffer offset of the current stored row; the
    // top border row shares base 0 with the first interior row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q <= '0;
        end else if (issue && pos_wrap) begin
            if (pos_last)
                row_base_q <= '0;
            else if (!PAD_EN || (pos_row != '0))
                row_base_q <= row_base_q + ADDR_W'(IMG_W);
        end
    end

    assign addr_full = row_base_q + ADDR_W'(pos_col) - ADDR_W'(PAD);
    assign mem_addr  = rd_now ? addr_full : '0;
    assign mem_rd_en = rd_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= issue;
            rd_q    <= rd_now;
            last_q  <= issue && pos_last;
            done_q  <= (state_q == FLUSH);
            hold_q  <= pixel_out;
        end
    end

    // The buffer's read register supplies the pixel stage; hold_q keeps the
    // last value visible on idle cycles.
    assign pixel_out  = en_q ? (rd_q ? mem_rdata : '0) : hold_q;
    assign pixel_en   = en_q;
    assign frame_last = last_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// tb/tb_fmap_pixel_streamer.sv - self-checking bench for fmap_pixel_streamer (4x4 map)
module tb_fmap_pixel_streamer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int AW = 4;
`ifdef STREAM_ZERO_PAD_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int OW = W + 2 * P;
    localparam int OH = H + 2 * P;
    localparam int NPIX = OW * OH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              ready = 1'b0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic signed [7:0] mem_rdata = '0;
    logic signed [7:0] pixel_out;
    logic              pixel_en;
    logic              frame_last;
    logic              busy;
    logic              done;

    fmap_pixel_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .pixel_out  (pixel_out),
        .pixel_en   (pixel_en),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [0:W*H-1];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit ready_log [0:8191];

    logic signed [7:0] pq[$];
    int                pcyc[$];
    bit                plast[$];
    int                done_cnt = 0;
    int                addr_bad = 0;
    int                hold_bad = 0;
    int                stray_last = 0;
    bit                mon_on = 1'b0;
    logic signed [7:0] last_pix = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (pixel_en) begin
                pq.push_back(pixel_out);
                pcyc.push_back(cyc);
                plast.push_back(frame_last);
                last_pix = pixel_out;
            end else begin
                if (pixel_out !== last_pix) hold_bad++;
                if (frame_last) stray_last++;
            end
            if (done) done_cnt++;
            if (mem_rd_en && (int'(mem_addr) > W * H - 1)) addr_bad++;
            if (rst) last_pix = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_cycle(input bit r);
        ready = r;
        ready_log[cyc] = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [7:0] exp_pix(input int k);
        int r, c;
        r = k / OW;
        c = k % OW;
        if (P == 1) begin
            if (r == 0 || r == OH - 1 || c == 0 || c == OW - 1) return 8'sd0;
            return mem[(r - 1) * W + (c - 1)];
        end
        return mem[r * W + c];
    endfunction

    task automatic run_frame(input bit rnd, input bit repulse, output int t0, output int tdone);
        int n;
        start = 1'b1;
        t0 = cyc;
        drive_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        n = 0;
        while (!done && n < 3000) begin
            start = repulse && (n == 5);
            drive_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        start = 1'b0;
        tdone = done ? cyc : -1;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_frame(input int t0, input int tdone, input int base);
        int r, expc;
        r = t0;
        expc = 0;
        chk("pix_count", pq.size() - base, NPIX);
        for (int k = 0; k < NPIX; k++) begin
            r++;
            while (ready_log[r] == 1'b0 && r < 8190) r++;
            expc = r + 1;
            if (base + k < pq.size()) begin
                chk("pix_val", 32'(pq[base + k]), 32'(exp_pix(k)));
                chk("pix_cyc", pcyc[base + k], expc);
                chk("pix_last", {31'd0, plast[base + k]}, {31'd0, k == NPIX - 1});
            end
        end
        chk("done_cyc", tdone, expc + 1);
    endtask

    initial begin
        int t0, td, t1, td1, dc, base;
        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
        repeat (3) drive_cycle(1'b1);
        rst = 1'b0;
        mon_on = 1'b1;

        chk("rst_pixel_en", {31'd0, pixel_en}, 32'd0);
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_frame_last", {31'd0, frame_last}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        repeat (3) drive_cycle(1'b1);

        // full-throughput frame
        pq.delete(); pcyc.delete(); plast.delete();
        run_frame(1'b0, 1'b0, t0, td);
        check_frame(t0, td, 0);
        chk("first_pix_latency", pcyc.size() > 0 ? pcyc[0] - t0 : -1, 2);
        repeat (4) drive_cycle(1'b1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);

        // throttled frames with fresh buffer contents
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
            pq.delete(); pcyc.delete(); plast.delete();
            run_frame(1'b1, 1'b0, t0, td);
            check_frame(t0, td, 0);
            repeat (3) drive_cycle(1'b1);
        end

        // start re-pulsed while busy is ignored
        pq.delete(); pcyc.delete(); plast.delete();
        dc = done_cnt;
        run_frame(1'b0, 1'b1, t0, td);
        check_frame(t0, td, 0);
        repeat (10) drive_cycle(1'b1);
        chk("repulse_pix_count", pq.size(), NPIX);
        chk("repulse_done_count", done_cnt - dc, 1);

        // back-to-back frames: second start in the done cycle
        pq.delete(); pcyc.delete(); plast.delete();
        run_frame(1'b1, 1'b0, t0, td);
        check_frame(t0, td, 0);
        base = pq.size();
        run_frame(1'b0, 1'b0, t1, td1);
        chk("b2b_start_cyc", t1, td);
        check_frame(t1, td1, base);
        repeat (3) drive_cycle(1'b1);

        // reset at the 10th pixel
        pq.delete(); pcyc.delete(); plast.delete();
        start = 1'b1;
        drive_cycle(1'b1);
        start = 1'b0;
        for (int n = 0; n < 200 && !(pixel_en && pq.size() == 9); n++) drive_cycle(1'b1);
        chk("rst10_at_pixel", {31'd0, pixel_en}, 32'd1);
        dc = done_cnt;
        rst = 1'b1;
        drive_cycle(1'b1);
        chk("rst10_pixel_en", {31'd0, pixel_en}, 32'd0);
        chk("rst10_busy", {31'd0, busy}, 32'd0);
        chk("rst10_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (8) drive_cycle(1'b1);
        chk("rst10_pix_count", pq.size(), 10);
        chk("rst10_no_done", done_cnt - dc, 0);
        pq.delete(); pcyc.delete(); plast.delete();
        run_frame(1'b1, 1'b0, t0, td);
        check_frame(t0, td, 0);
        repeat (3) drive_cycle(1'b1);

        chk("addr_in_range", addr_bad, 0);
        chk("pixel_hold", hold_bad, 0);
        chk("stray_frame_last", stray_last, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
